// File: rtl/rr_mux_sched.sv
// Round-robin scheduler for a shared FP ALU: picks one of 16 requesters, drives the
// operand-mux select, launches the unit with a one-cycle start, and aborts on a watchdog.
//
// state | meaning
// IDLE  | no transaction; arbitrate among pending requests from ptr onward
// BUSY  | granted requester owns the operand path until done or watchdog
module rr_mux_sched #(
  parameter int N       = 16,
  parameter int SELW    = 4,
  parameter int TIMEOUT = 255,
  parameter int CNTW    = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [0:N-1]    req,
  input  logic            done,
  output logic [0:N-1]    grant,
  output logic [0:SELW-1] sel,
  output logic            start,
  output logic            busy,
  output logic            timeout_err,
  output logic            err_sticky
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state;
  logic [SELW-1:0] ptr;
  logic [CNTW-1:0] cnt;
  logic [SELW-1:0] pick;
  logic            found;

  // Rotating priority search: ptr has highest priority, wrapping modulo N.
  always_comb begin
    logic [SELW-1:0] idx;
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      idx = ptr + SELW'(k);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      grant       <= '0;
      sel         <= '0;
      start       <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      err_sticky  <= 1'b0;
      ptr         <= '0;
      cnt         <= '0;
    end else begin
      start       <= 1'b0;
      timeout_err <= 1'b0;
      if (state == IDLE) begin
        if (found) begin
          sel         <= pick;
          grant       <= '0;
          grant[pick] <= 1'b1;
          start       <= 1'b1;
          busy        <= 1'b1;
          cnt         <= '0;
          state       <= BUSY;
        end
      end else begin
        // done takes precedence over a watchdog expiring on the same edge
        if (done || (cnt == CNTW'(TIMEOUT - 1))) begin
          grant       <= '0;
          busy        <= 1'b0;
          ptr         <= SELW'(sel) + SELW'(1);
          state       <= IDLE;
          if (!done) begin
            timeout_err <= 1'b1;
            err_sticky  <= 1'b1;
          end
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_rr_mux_sched.sv
// Self-checking bench for rr_mux_sched: directed scenarios plus randomized traffic
// compared against a transaction-level reference model.
module tb_rr_mux_sched;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        done = 1'b0;
  logic [0:15] req = '0;
  logic [0:15] grant;
  logic [0:3]  sel;
  logic        start, busy, timeout_err, err_sticky;
  logic [23:0] obs;

  int errors = 0;
  int checks = 0;

  // reference model: who is being served, for how many busy edges, and the rotation point
  bit       m_busy = 0;
  int       m_w = 0;
  int       m_ptr = 0;
  int       m_age = 0;
  logic [3:0] m_sel = '0;
  bit       m_start = 0, m_terr = 0, m_sticky = 0;

  rr_mux_sched #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req(req), .done(done), .grant(grant), .sel(sel),
    .start(start), .busy(busy), .timeout_err(timeout_err), .err_sticky(err_sticky)
  );

  assign obs = {grant, sel, start, busy, timeout_err, err_sticky};

  always #5 clk = ~clk;

  function automatic logic [23:0] exp_vec();
    logic [0:15] g;
    g = '0;
    if (m_busy) g[m_w] = 1'b1;
    return {g, m_sel, m_start, m_busy, m_terr, m_sticky};
  endfunction

  task automatic step(input logic [0:15] r, input logic d, input logic rs);
    bit hit;
    req = r; done = d; reset = rs;
    @(posedge clk);
    m_start = 0;
    m_terr  = 0;
    if (rs) begin
      m_busy = 0; m_ptr = 0; m_age = 0; m_sel = '0; m_sticky = 0;
    end else if (!m_busy) begin
      hit = 0;
      for (int k = 0; k < 16; k++)
        if (!hit && r[(m_ptr + k) % 16]) begin
          m_w = (m_ptr + k) % 16;
          hit = 1;
        end
      if (hit) begin
        m_busy = 1; m_start = 1; m_age = 0; m_sel = 4'(m_w);
      end
    end else begin
      m_age++;
      if (d || m_age >= TO) begin
        if (!d) begin m_terr = 1; m_sticky = 1; end
        m_busy = 0;
        m_ptr  = (m_w + 1) % 16;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    step(16'hFFFF, 1'b1, 1'b1);
    step(16'hFFFF, 1'b1, 1'b1);
    if (obs !== 24'h0) begin errors++; $display("FAIL reset_outputs: got %h want %h", obs, 24'h0); end
    checks++;
    step(16'h0, 1'b0, 1'b0);
    if (obs !== exp_vec()) begin errors++; $display("FAIL reset_idle: got %h want %h", obs, exp_vec()); end
    checks++;
  endtask

  task automatic test_single();
    logic [0:15] r0;
    r0 = 16'b1000_0000_0000_0000;
    step(r0, 1'b0, 1'b0);
    if (grant !== 16'h8000 || sel !== 4'b0000 || start !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL single_grant: got g=%h s=%h st=%b b=%b want g=8000 s=0 st=1 b=1", grant, sel, start, busy);
    end
    checks++;
    step(r0, 1'b0, 1'b0);
    if (start !== 1'b0 || grant !== 16'h8000) begin errors++; $display("FAIL single_pulse: got st=%b g=%h want st=0 g=8000", start, grant); end
    checks++;
    step(r0, 1'b0, 1'b0);
    step(r0, 1'b1, 1'b0);
    if (grant !== 16'h0 || busy !== 1'b0) begin errors++; $display("FAIL single_done: got g=%h b=%b want 0 0", grant, busy); end
    checks++;
    step(16'b1100_0000_0000_0000, 1'b0, 1'b0);
    if (sel !== 4'd1 || obs !== exp_vec()) begin errors++; $display("FAIL single_ptr: got sel=%0d want 1", sel); end
    checks++;
    step(16'h0, 1'b1, 1'b0);
  endtask

  task automatic test_rotation();
    int n = 0;
    bit prev = 0;
    step(16'h0, 1'b0, 1'b1);
    for (int c = 0; c < 40; c++) begin
      step(16'hFFFF, 1'b1, 1'b0);
      if (obs !== exp_vec()) begin errors++; $display("FAIL rot_model c%0d: got %h want %h", c, obs, exp_vec()); end
      checks++;
      if (start) begin
        if (sel !== 4'(n % 16)) begin errors++; $display("FAIL rot_seq n%0d: got %0d want %0d", n, sel, n % 16); end
        checks++;
        n++;
      end
      if (prev && start) begin errors++; $display("FAIL rot_double_start c%0d: got 1 want 0", c); end
      if (!$onehot0(grant)) begin errors++; $display("FAIL rot_onehot c%0d: got %h", c, grant); end
      checks += 2;
      prev = start;
    end
    if (n !== 20) begin errors++; $display("FAIL rot_count: got %0d want 20", n); end
    checks++;
  endtask

  task automatic test_fairness();
    int order[3];
    int n = 0;
    logic [0:15] r;
    r = '0; r[3] = 1'b1; r[12] = 1'b1;
    step(16'h0, 1'b0, 1'b1);
    for (int c = 0; c < 8; c++) begin
      step(r, 1'b1, 1'b0);
      if (obs !== exp_vec()) begin errors++; $display("FAIL fair_model c%0d: got %h want %h", c, obs, exp_vec()); end
      checks++;
      if (start && n < 3) begin order[n] = int'(sel); n++; end
    end
    if (n !== 3 || order[0] !== 3 || order[1] !== 12 || order[2] !== 3) begin
      errors++; $display("FAIL fair_order: got n=%0d %0d,%0d,%0d want 3,12,3", n, order[0], order[1], order[2]);
    end
    checks++;
  endtask

  task automatic test_watchdog();
    logic [0:15] r6, r67;
    int nb = 1;
    bit ended = 0;
    r6 = '0; r6[6] = 1'b1;
    r67 = r6; r67[7] = 1'b1;
    step(16'h0, 1'b0, 1'b1);
    step(r6, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      if (!ended) begin
        step(r6, 1'b0, 1'b0);
        if (obs !== exp_vec()) begin errors++; $display("FAIL wd_model i%0d: got %h want %h", i, obs, exp_vec()); end
        checks++;
        if (busy) nb++;
        else ended = 1;
      end
    end
    if (!ended || nb !== TO || timeout_err !== 1'b1 || grant !== 16'h0) begin
      errors++; $display("FAIL wd_abort: got busy_cycles=%0d terr=%b g=%h want %0d 1 0", nb, timeout_err, grant, TO);
    end
    checks++;
    step(16'h0, 1'b0, 1'b0);
    if (timeout_err !== 1'b0 || err_sticky !== 1'b1) begin errors++; $display("FAIL wd_pulse: got terr=%b sticky=%b want 0 1", timeout_err, err_sticky); end
    checks++;
    step(r67, 1'b0, 1'b0);
    if (sel !== 4'd7 || start !== 1'b1) begin errors++; $display("FAIL wd_next: got sel=%0d st=%b want 7 1", sel, start); end
    checks++;
    step(16'h0, 1'b1, 1'b0);
    if (err_sticky !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL wd_sticky: got sticky=%b busy=%b want 1 0", err_sticky, busy); end
    checks++;
  endtask

  task automatic test_reset_mid();
    logic [0:15] r10, r0_10;
    r10 = '0; r10[10] = 1'b1;
    r0_10 = r10; r0_10[0] = 1'b1;
    step(16'h0, 1'b0, 1'b1);
    step(r10, 1'b0, 1'b0);
    if (sel !== 4'b1010) begin errors++; $display("FAIL rm_grant: got sel=%b want 1010", sel); end
    checks++;
    step(r10, 1'b0, 1'b0);
    step(r10, 1'b0, 1'b0);
    step(r10, 1'b0, 1'b1);
    if (obs !== 24'h0) begin errors++; $display("FAIL rm_abort: got %h want %h", obs, 24'h0); end
    checks++;
    step(r0_10, 1'b0, 1'b0);
    if (sel !== 4'd0 || grant !== 16'h8000) begin errors++; $display("FAIL rm_ptr: got sel=%0d g=%h want 0 8000", sel, grant); end
    checks++;
    step(16'h0, 1'b1, 1'b0);
  endtask

  task automatic test_ignored();
    logic [0:15] r5, r9;
    r5 = '0; r5[5] = 1'b1;
    r9 = '0; r9[9] = 1'b1;
    step(16'h0, 1'b0, 1'b1);
    step(16'h0, 1'b1, 1'b0);
    step(16'h0, 1'b1, 1'b0);
    if (obs !== 24'h0) begin errors++; $display("FAIL ign_done_idle: got %h want %h", obs, 24'h0); end
    checks++;
    step(r5, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(16'h0, 1'b0, 1'b0);
      if (grant !== 16'h0400 || sel !== 4'b0101 || busy !== 1'b1) begin
        errors++; $display("FAIL ign_drop i%0d: got g=%h sel=%b want 0400 0101", i, grant, sel);
      end
      checks++;
    end
    step(16'h0, 1'b1, 1'b0);
    step(16'h0, 1'b0, 1'b0);
    step(r9, 1'b0, 1'b0);
    for (int i = 0; i < TO - 1; i++) step(r9, 1'b0, 1'b0);
    step(r9, 1'b1, 1'b0);
    if (timeout_err !== 1'b0 || err_sticky !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL ign_done_vs_wd: got terr=%b sticky=%b busy=%b want 0 0 0", timeout_err, err_sticky, busy);
    end
    checks++;
  endtask

  task automatic test_random();
    logic [0:15] r;
    logic d, rs;
    bit prev = 0;
    step(16'h0, 1'b0, 1'b1);
    for (int c = 0; c < 3000; c++) begin
      r  = 16'($urandom) & 16'($urandom);
      d  = ($urandom_range(0, 3) == 0);
      rs = ($urandom_range(0, 299) == 0);
      step(r, d, rs);
      if (obs !== exp_vec()) begin errors++; $display("FAIL rand_model c%0d: got %h want %h", c, obs, exp_vec()); end
      checks++;
      if (!$onehot0(grant) || (grant != 0 && !grant[sel]) || (start && !busy) || (start && prev)) begin
        errors++; $display("FAIL rand_invariant c%0d: got g=%h sel=%0d st=%b b=%b", c, grant, sel, start, busy);
      end
      checks++;
      prev = start;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_rotation();
    test_fairness();
    test_watchdog();
    test_reset_mid();
    test_ignored();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rr_mux_sched.md
Name: rr_mux_sched

Overview:
- Round-robin scheduler that shares one FP ALU operand path among 16 requesters.
- Drives the 4-bit select of the 16:1 operand mux (mux_16to1) and hands a one-cycle start to the shared unit.
- Waits for the unit's done, then moves priority to the next requester.
- Has a watchdog timeout so a hung unit cannot lock the path.

Parameters:
- N, 16: number of requesters; fixed to match the 16:1 mux.
- SELW, 4: select width, log2(N).
- TIMEOUT, 255: maximum BUSY cycles without done before abort (1..255).
- CNTW, 8: width of the busy-cycle counter; must hold TIMEOUT.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  [0:15]  request lines; req[i] requests mux input in[i]. Ascending bit order, same as the mux.
- done  in  1  shared unit finished the current operation.
- grant  out  [0:15]  one-hot grant; grant[i] high for the whole transaction.
- sel  out  [0:3]  mux select; value i selects in[i] (sel=4'b0000 selects in[0]).
- start  out  1  one-cycle pulse launching the shared unit.
- busy  out  1  high while a transaction is in progress.
- timeout_err  out  1  one-cycle pulse on watchdog abort.
- err_sticky  out  1  set by any timeout; cleared only by reset.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. With reset high at an edge, the following are all 0 / IDLE:
  - state=IDLE, grant=0, sel=0, start=0, busy=0, timeout_err=0, err_sticky=0;
  - priority pointer ptr=0, busy counter cnt=0.
- Reset mid-BUSY aborts the transaction silently: no timeout_err pulse, ptr returns to 0.
- All outputs are registered. No combinational path from inputs to outputs.
- State IDLE:
  - If req != 0 at edge k, pick w = first i with req[i]=1, searching ptr, ptr+1, ..., 15, 0, ..., ptr-1 (mod 16).
  - At edge k: sel=w, grant=one-hot(w), start=1, busy=1, cnt=0, state=BUSY.
  - Latency from req sampled to start/grant visible is one cycle.
  - If req == 0: stay in IDLE. done is ignored in IDLE.
- State BUSY:
  - start is forced to 0 after its single cycle. grant and sel are held stable.
  - done is sampled at every edge in BUSY, including the cycle where start=1, so a zero-latency unit is legal.
  - done=1 at an edge: grant=0, busy=0, ptr=(w+1) mod 16 (wraps 15->0), state=IDLE.
  - Otherwise cnt increments.
  - Timeout: cnt==TIMEOUT-1 with done=0 at an edge. Same actions as done, plus timeout_err=1 for one cycle and err_sticky=1.
  - done and timeout at the same edge: done wins, no error.
- Requests are not retractable. Changes on req during BUSY have no effect; the granted transaction runs to done or timeout.
- At least one IDLE cycle separates consecutive grants. Minimum per-transaction period is 2 cycles.
- Requester protocol: hold req[i] until grant[i] falls. Re-asserting req[i] afterwards queues it behind the other requesters.
- Invariants:
  - grant is zero or one-hot.
  - When grant != 0, grant[sel]=1.
  - start=1 only while busy=1, never on two consecutive cycles.

Test Plan:
- Single request: reset, then req=16'b1000_0000_0000_0000, done asserted 3 cycles after start.
  - Response: next edge sel=4'b0000, grant=16'h8000, start=1 for one cycle, busy=1.
  - grant=0, busy=0 the edge after done; ptr=1.
- Full rotation with wrap: req=16'hFFFF held, done=1 constantly.
  - Response: sel sequence 0,1,2,...,15,0,1 with one IDLE cycle between grants.
  - Each start is a single-cycle pulse; grant is one-hot throughout.
- Fairness: req[3] and req[12] both held, ptr=0.
  - Response: 3 is served first; then 12 is served even though req[3] is still high; then 3 again.
- Watchdog: TIMEOUT=8, one request, done never asserted.
  - Response: after 8 BUSY cycles grant=0 and timeout_err pulses for 1 cycle.
  - err_sticky=1 and stays 1; ptr advanced; a new request is granted normally.
- Reset mid-operation: assert reset during BUSY on sel=4'b1010.
  - Response: next edge all outputs 0, no timeout_err pulse.
  - After release, a request on 10 and 0 grants 0 first (ptr=0).
- Ignored events:
  - done pulsed in IDLE gives no state change.
  - Dropping req[5] mid-BUSY keeps grant[5] and sel=4'b0101 until done.
  - done coinciding with cnt==TIMEOUT-1 gives no timeout_err.
